// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH one bit per clock,
// LSB first, using one full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH:0]   res_cat;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             d_bit;
   logic             br_next;
   logic             last_bit;

   // Full-subtractor cell; the new difference bit enters the result from the MSB side
   always_comb begin
      d_bit    = a_sh[0] ^ b_sh[0] ^ br;
      br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
      res_cat  = {d_bit, res_sh};
      res_next = res_cat[WIDTH:1];
      last_bit = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // diff/borrow are only written on the final RUN cycle so the previous result stays visible
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  res_sh <= '0;
                  cnt    <= '0;
                  br     <= 1'b0;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_next;
               br     <= br_next;
               cnt    <= cnt + CW'(1);
               if (last_bit) begin
                  diff   <= res_next;
                  borrow <= br_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: table-driven WIDTH=8 vectors, start-hold,
// mid-operation reset and WIDTH=1 sequences.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       busy8;
   logic       done8;
   logic [7:0] diff8;
   logic       borrow8;
   logic       start1 = 1'b0;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       busy1;
   logic       done1;
   logic [0:0] diff1;
   logic       borrow1;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_diff;
      logic       exp_borrow;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
   );

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      else passed++;
   endtask

   // Runs one WIDTH=8 operation; start may be left high for the hold test
   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic keep_start,
                                input logic [7:0] prev_diff, output int lat, output int busy_cnt);
      bit seen = 0;
      bit held_ok = 1;
      bit excl_ok = 1;
      @(negedge clk);
      start8 = 1'b1; a8 = av; b8 = bv;
      @(posedge clk);
      #1;
      if (!keep_start) start8 = 1'b0;
      a8 = ~av; b8 = ~bv;
      lat = 1; busy_cnt = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (busy8 && done8) excl_ok = 0;
         if (done8) seen = 1;
         else begin
            if (busy8) busy_cnt++;
            if (diff8 !== prev_diff) held_ok = 0;
            @(posedge clk);
            lat++;
         end
      end
      checkOutput("done_seen", 32'(seen), 32'd1);
      checkOutput("diff_held_during_run", 32'(held_ok), 32'd1);
      checkOutput("busy_done_exclusive", 32'(excl_ok), 32'd1);
   endtask

   initial begin
      int lat;
      int bcnt;
      logic [7:0] prev;
      bit no_done;

      vecs[0] = '{8'd200, 8'd55,  8'd145, 1'b0};
      vecs[1] = '{8'd5,   8'd9,   8'd252, 1'b1};
      vecs[2] = '{8'd0,   8'd255, 8'd1,   1'b1};
      vecs[3] = '{8'hA5,  8'hA5,  8'd0,   1'b0};
      vecs[4] = '{8'd255, 8'd0,   8'd255, 1'b0};
      vecs[5] = '{8'd0,   8'd1,   8'd255, 1'b1};
      vecs[6] = '{8'd200, 8'd55,  8'd145, 1'b0};

      #12;
      checkOutput("reset_busy", 32'(busy8), 32'd0);
      checkOutput("reset_done", 32'(done8), 32'd0);
      checkOutput("reset_diff", 32'(diff8), 32'd0);
      checkOutput("reset_borrow", 32'(borrow8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      prev = 8'd0;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, 1'b0, prev, lat, bcnt);
         checkOutput($sformatf("vec%0d_diff", i), 32'(diff8), 32'(vecs[i].exp_diff));
         checkOutput($sformatf("vec%0d_borrow", i), 32'(borrow8), 32'(vecs[i].exp_borrow));
         checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
         checkOutput($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd8);
         prev = vecs[i].exp_diff;
         @(posedge clk);
      end

      // start held high: operands change to 7/7 during RUN, next capture only once back in IDLE
      applyStimulus(8'd100, 8'd1, 1'b1, prev, lat, bcnt);
      a8 = 8'd7; b8 = 8'd7;
      checkOutput("hold_diff", 32'(diff8), 32'd99);
      checkOutput("hold_borrow", 32'(borrow8), 32'd0);
      @(negedge clk);
      checkOutput("hold_idle_after_done", 32'(busy8), 32'd0);
      @(negedge clk);
      checkOutput("hold_recapture", 32'(busy8), 32'd1);
      start8 = 1'b0;
      for (int i = 0; i < 20 && !done8; i++) @(negedge clk);
      checkOutput("hold_second_diff", 32'(diff8), 32'd0);
      checkOutput("hold_second_borrow", 32'(borrow8), 32'd0);
      @(negedge clk);

      // reset asserted while bit 3 is being processed
      start8 = 1'b1; a8 = 8'd200; b8 = 8'd55;
      @(posedge clk);
      #1 start8 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy8), 32'd0);
      checkOutput("abort_done", 32'(done8), 32'd0);
      checkOutput("abort_diff", 32'(diff8), 32'd0);
      checkOutput("abort_borrow", 32'(borrow8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      no_done = 1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8 || busy8) no_done = 0;
      end
      checkOutput("abort_no_done", 32'(no_done), 32'd1);
      applyStimulus(8'd30, 8'd10, 1'b0, 8'd0, lat, bcnt);
      checkOutput("after_abort_diff", 32'(diff8), 32'd20);
      checkOutput("after_abort_borrow", 32'(borrow8), 32'd0);
      @(posedge clk);

      // WIDTH=1 instance
      for (int i = 0; i < 3; i++) begin
         logic [1:0] ab;
         logic [1:0] exp;
         int l1;
         ab  = (i == 0) ? 2'b10 : (i == 1) ? 2'b01 : 2'b11;
         exp = (i == 0) ? 2'b10 : (i == 1) ? 2'b11 : 2'b00;
         @(negedge clk);
         start1 = 1'b1; a1 = ab[1]; b1 = ab[0];
         @(posedge clk);
         #1 start1 = 1'b0;
         l1 = 1;
         for (int k = 0; k < 10 && !done1; k++) begin
            @(negedge clk);
            if (!done1) begin
               @(posedge clk);
               l1++;
            end
         end
         checkOutput($sformatf("w1_case%0d_latency", i), 32'(l1), 32'd2);
         checkOutput($sformatf("w1_case%0d_diff", i), 32'(diff1), 32'(exp[1]));
         checkOutput($sformatf("w1_case%0d_borrow", i), 32'(borrow1), 32'(exp[0]));
         @(posedge clk);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
